// File: rtl/batch_tid_dispatcher.sv
// batch_tid_dispatcher: issues LANES consecutive thread IDs per handshake with per-lane (x,y,z) coordinates
module batch_tid_dispatcher #(
  parameter int TOTAL_TID = 512,
  parameter int LANES = 4,
  localparam int TID_W = $clog2(TOTAL_TID + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clr,
  input  logic [TID_W-1:0]       max_tid,
  input  logic [TID_W-1:0]       ntid_x,
  input  logic [TID_W-1:0]       ntid_y,
  input  logic [TID_W-1:0]       ntid_z,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TID_W-1:0]       out_base_tid,
  output logic [LANES-1:0]       out_lane_mask,
  output logic [LANES*TID_W-1:0] out_tid_x,
  output logic [LANES*TID_W-1:0] out_tid_y,
  output logic [LANES*TID_W-1:0] out_tid_z,
  output logic                   busy,
  output logic                   done
);
  localparam int BW = TID_W + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [BW-1:0] base;
  logic [TID_W-1:0] mx, nx, ny, nz, bx, by, bz, x, y, z;
  logic wx, wy, last, hs, launch;
  logic [LANES-1:0] mask;
  logic [LANES*TID_W-1:0] tx, ty, tz;
  assign out_valid = state == RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign hs = out_valid && out_ready;
  assign launch = !clr && state != RUN && start;
  assign last = base + BW'(LANES - 1) >= {1'b0, mx};
  assign out_base_tid = out_valid ? base[TID_W-1:0] : '0;
  assign out_lane_mask = mask;
  assign out_tid_x = tx;
  assign out_tid_y = ty;
  assign out_tid_z = tz;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = clr ? IDLE : launch ? RUN : (hs && last) ? DONE : state;
  // Walk the coordinate chain lane by lane; after the loop x/y/z hold the next batch's base coords.
  always_comb begin
    x = bx;
    y = by;
    z = bz;
    wx = 1'b0;
    wy = 1'b0;
    mask = '0;
    tx = '0;
    ty = '0;
    tz = '0;
    for (int i = 0; i < LANES; i++) begin
      mask[i] = out_valid && (base + BW'(i) <= {1'b0, mx});
      if (mask[i]) begin
        tx[i*TID_W +: TID_W] = x;
        ty[i*TID_W +: TID_W] = y;
        tz[i*TID_W +: TID_W] = z;
      end
      wx = x == nx;
      wy = y == ny;
      z = (wx && wy) ? ((z == nz) ? '0 : z + 1'b1) : z;
      y = wx ? (wy ? '0 : y + 1'b1) : y;
      x = wx ? '0 : x + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      base <= '0;
      {mx, nx, ny, nz, bx, by, bz} <= '0;
    end else if (launch) begin
      base <= '0;
      {mx, nx, ny, nz} <= {max_tid, ntid_x, ntid_y, ntid_z};
      {bx, by, bz} <= '0;
    end else if (!clr && hs && !last) begin
      base <= base + BW'(LANES);
      {bx, by, bz} <= {x, y, z};
    end
endmodule
